// File: rtl/i2s_pkg.sv
// Shared definitions for the left-justified I2S blocks (receiver and transmitter).
// Contents:
//   AUDIO_DW_DEFAULT - default sample word width, also the prescaler/bit counter width
//   rx_state_e       - receiver framing state (SYNC, LEFT, RIGHT)
package i2s_pkg;

  localparam int AUDIO_DW_DEFAULT = 32;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,  // waiting for the first lrclk fall
    LEFT  = 2'd1,  // receiving the left channel
    RIGHT = 2'd2   // receiving the right channel
  } rx_state_e;

endpackage

// File: rtl/i2s_rx_slave_lj_if.sv
// Parallel stereo-pair output bus of the LJ receiver.
// Signals:
//   left_chan  - received left word
//   right_chan - received right word
//   out_valid  - a pair is available
//   out_ready  - consumer accepts the pair
// Modports: master (receiver side), slave (downstream consumer side).
interface i2s_rx_slave_lj_if
  import i2s_pkg::*;
#(
  parameter int AUDIO_DW = AUDIO_DW_DEFAULT
) ();

  logic [AUDIO_DW-1:0] left_chan;
  logic [AUDIO_DW-1:0] right_chan;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output left_chan,
    output right_chan,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  left_chan,
    input  right_chan,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/i2s_lr_edge.sv
// Word-select edge detector: registers lrclk once per sclk and flags its edges.
// Ports:
//   sclk  - bit clock
//   lrclk - word select from the external master
//   rise  - lrclk went 0 -> 1 (combinational, valid in the detecting cycle)
//   fall  - lrclk went 1 -> 0 (combinational, valid in the detecting cycle)
module i2s_lr_edge (
  input  logic sclk,
  input  logic lrclk,
  output logic rise,
  output logic fall
);

  logic lr_d;

  // The delayed copy loads lrclk both in and out of reset, so the cycle after
  // reset never sees a stale value and cannot report a false edge. No reset
  // branch is therefore needed here.
  always_ff @(posedge sclk) begin
    lr_d <= lrclk;
  end

  assign fall = lr_d & ~lrclk;
  assign rise = ~lr_d & lrclk;

endmodule

// File: rtl/i2s_rx_slave_lj.sv
// Left-justified I2S receiver, slave mode.
// Samples sdata on rising sclk inside frames delimited by an external lrclk
// (0 = left, 1 = right), deserialises MSB-first words and presents each
// completed stereo pair on a single-entry valid/ready output register.
// Ports:
//   sclk      - bit clock, sole clock
//   rst       - synchronous active-high reset
//   prescaler - expected sclk cycles per channel (static while out of reset)
//   lrclk     - word select, sdata - serial data
//   out_if    - pair output bus (left_chan, right_chan, out_valid, out_ready)
//   overflow  - 1-cycle pulse: a pair was overwritten before being accepted
//   frame_err - 1-cycle pulse: channel length differed from prescaler
// Build option: I2S_RX_FRAME_CHECK_EN enables the channel-length check;
// without it frame_err is tied low.
module i2s_rx_slave_lj
  import i2s_pkg::*;
#(
  parameter int AUDIO_DW = AUDIO_DW_DEFAULT
) (
  input  logic                  sclk,
  input  logic                  rst,
  input  logic [AUDIO_DW-1:0]   prescaler,
  input  logic                  lrclk,
  input  logic                  sdata,
  i2s_rx_slave_lj_if.master     out_if,
  output logic                  overflow,
  output logic                  frame_err
);

  localparam logic [AUDIO_DW-1:0] DW_LIMIT = AUDIO_DW'(AUDIO_DW);
  localparam logic [AUDIO_DW-1:0] MSB_ONE  = {1'b1, {(AUDIO_DW-1){1'b0}}};

  rx_state_e           state_q, state_d;
  logic                rise, fall;
  logic                chan_start, left_end, commit;
  logic [AUDIO_DW-1:0] bit_cnt;
  logic [AUDIO_DW-1:0] shift_q;
  logic [AUDIO_DW-1:0] left_buf;
  logic [AUDIO_DW-1:0] left_q, right_q;
  logic                valid_q;

  i2s_lr_edge u_lr_edge (
    .sclk  (sclk),
    .lrclk (lrclk),
    .rise  (rise),
    .fall  (fall)
  );

  always_ff @(posedge sclk) begin
    if (rst) state_q <= SYNC;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_d    = state_q;
    chan_start = 1'b0;
    left_end   = 1'b0;
    commit     = 1'b0;
    unique case (state_q)
      SYNC: begin
        // A rise here is ignored: only a fall marks a frame boundary.
        if (fall) begin
          state_d    = LEFT;
          chan_start = 1'b1;
        end
      end
      LEFT: begin
        if (rise) begin
          state_d    = RIGHT;
          chan_start = 1'b1;
          left_end   = 1'b1;
        end
      end
      RIGHT: begin
        if (fall) begin
          state_d    = LEFT;
          chan_start = 1'b1;
          commit     = 1'b1;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  // Deserialiser. The shift word starts at zero each channel, so bits are
  // OR-ed into place and a short channel leaves its LSBs at 0.
  // NOTE: non-blocking assignments mean left_buf and right_q below capture
  // the finished word of the ending channel, not the restarted one.
  always_ff @(posedge sclk) begin
    if (rst) begin
      bit_cnt  <= '0;
      shift_q  <= '0;
      left_buf <= '0;
    end else begin
      if (chan_start) begin
        shift_q <= MSB_ONE & {AUDIO_DW{sdata}};
        bit_cnt <= AUDIO_DW'(1);
      end else if (state_q != SYNC) begin
        if ((bit_cnt < DW_LIMIT) && (bit_cnt < prescaler))
          shift_q <= shift_q | ({AUDIO_DW{sdata}} & (MSB_ONE >> bit_cnt));
        if (bit_cnt != '1)
          bit_cnt <= bit_cnt + 1'b1;
      end
      if (left_end)
        left_buf <= shift_q;
    end
  end

  // Single-entry output register. A commit always wins: it reloads the pair
  // and keeps valid high, even when the old pair is accepted in that cycle.
  always_ff @(posedge sclk) begin
    if (rst) begin
      left_q   <= '0;
      right_q  <= '0;
      valid_q  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      overflow <= commit & valid_q & ~out_if.out_ready;
      if (commit) begin
        left_q  <= left_buf;
        right_q <= shift_q;
        valid_q <= 1'b1;
      end else if (valid_q && out_if.out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_if.left_chan  = left_q;
  assign out_if.right_chan = right_q;
  assign out_if.out_valid  = valid_q;

`ifdef I2S_RX_FRAME_CHECK_EN
  // bit_cnt equals the number of sclk cycles spent in the channel when the
  // ending edge is detected.
  logic frame_err_q;
  logic chan_end;

  assign chan_end = left_end | commit;

  always_ff @(posedge sclk) begin
    if (rst) frame_err_q <= 1'b0;
    else     frame_err_q <= chan_end && (bit_cnt != prescaler);
  end

  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_rx_slave_lj.sv
// Self-checking bench for i2s_rx_slave_lj: an LJ master model drives lrclk and
// sdata on falling sclk; expected words come from a channel-level model.
module tb_i2s_rx_slave_lj;
  import i2s_pkg::*;

  localparam int DW = AUDIO_DW_DEFAULT;

  logic          sclk = 1'b0;
  logic          rst  = 1'b1;
  logic [DW-1:0] prescaler = DW'(32);
  logic          lrclk = 1'b1;
  logic          sdata = 1'b0;
  logic          overflow;
  logic          frame_err;

  i2s_rx_slave_lj_if #(.AUDIO_DW(DW)) bus ();

  i2s_rx_slave_lj #(.AUDIO_DW(DW)) dut (
    .sclk      (sclk),
    .rst       (rst),
    .prescaler (prescaler),
    .lrclk     (lrclk),
    .sdata     (sdata),
    .out_if    (bus),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  always #5 sclk = ~sclk;

  int checks   = 0;
  int failures = 0;
  int valid_cnt, ovf_cnt, ferr_cnt;
  int exp_ferr, exp_pairs, cur_presc;
  int chk_stage;
  bit pair_pending;
  logic [DW-1:0] pend_l, pend_r, exp_l, exp_r;
  logic          exp_hold;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // A channel of len bits keeps its first min(len, DW, prescaler) bits, MSB
  // first; everything below is zero.
  function automatic logic [DW-1:0] model_word(input logic [DW-1:0] w, input int len,
                                               input int presc);
    int n;
    n = len;
    if (n > DW)    n = DW;
    if (n > presc) n = presc;
    return w & ~({DW{1'b1}} >> n);
  endfunction

  // One bit period: observe outputs at the falling edge, then drive the next bit.
  task automatic tick(input logic lr, input logic sd);
    @(negedge sclk);
    if (bus.out_valid) valid_cnt++;
    if (overflow)      ovf_cnt++;
    if (frame_err)     ferr_cnt++;
    if (chk_stage == 2) begin
      check("pair_left",  bus.left_chan,  exp_l);
      check("pair_right", bus.right_chan, exp_r);
      check("valid_set",  DW'(bus.out_valid), DW'(1));
      exp_hold  = ~bus.out_ready;
      chk_stage = 1;
    end else if (chk_stage == 1) begin
      check("valid_after", DW'(bus.out_valid), DW'(exp_hold));
      chk_stage = 0;
    end
    lrclk = lr;
    sdata = sd;
  endtask

  task automatic send_chan(input logic lr, input logic [DW-1:0] w, input int len,
                           input logic fill);
    for (int i = 0; i < len; i++) begin
      tick(lr, (i < DW) ? w[DW-1-i] : fill);
      // The first left bit is the fall that commits the previous pair.
      if (i == 0 && lr == 1'b0 && pair_pending) begin
        exp_l        = pend_l;
        exp_r        = pend_r;
        chk_stage    = 2;
        pair_pending = 1'b0;
      end
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] l, input int llen,
                            input logic [DW-1:0] r, input int rlen, input logic fill);
    send_chan(1'b0, l, llen, fill);
    send_chan(1'b1, r, rlen, fill);
    pend_l       = model_word(l, llen, cur_presc);
    pend_r       = model_word(r, rlen, cur_presc);
    pair_pending = 1'b1;
    exp_pairs++;
`ifdef I2S_RX_FRAME_CHECK_EN
    if (llen != cur_presc) exp_ferr++;
    if (rlen != cur_presc) exp_ferr++;
`endif
  endtask

  task automatic apply_reset(input logic lr, input int presc, input int n);
    chk_stage    = 0;
    pair_pending = 1'b0;
    rst          = 1'b1;
    prescaler    = DW'(presc);
    cur_presc    = presc;
    repeat (n) tick(lr, 1'b0);
    check("rst_valid", DW'(bus.out_valid), '0);
    check("rst_left",  bus.left_chan,  '0);
    check("rst_right", bus.right_chan, '0);
    check("rst_ovf",   DW'(overflow),  '0);
    check("rst_ferr",  DW'(frame_err), '0);
    rst       = 1'b0;
    valid_cnt = 0;
    ovf_cnt   = 0;
    ferr_cnt  = 0;
    exp_ferr  = 0;
    exp_pairs = 0;
  endtask

  task automatic end_test(input string tag, input int exp_ovf, input bit count_pairs);
    check({tag, "_ovf"},  DW'(ovf_cnt),  DW'(exp_ovf));
    check({tag, "_ferr"}, DW'(ferr_cnt), DW'(exp_ferr));
    if (count_pairs) check({tag, "_pairs"}, DW'(valid_cnt), DW'(exp_pairs));
  endtask

  logic [DW-1:0] p2_l, p2_r, wl, wr;

  initial begin
    bus.out_ready = 1'b1;

    // Basic frame, entered with lrclk high mid-right-channel after reset.
    apply_reset(1'b1, 32, 3);
    send_chan(1'b1, DW'($urandom), 10, 1'b0);
    send_frame(32'hA5A5_0001, 32, 32'h8000_00FF, 32, 1'b0);
    check("sync_no_early_valid", DW'(valid_cnt), '0);
    send_chan(1'b0, DW'($urandom), 4, 1'b0);
    end_test("basic", 0, 1'b1);

    // Randomised full-length frames.
    apply_reset(1'b1, 32, 2);
    for (int k = 0; k < 4; k++)
      send_frame(DW'($urandom), 32, DW'($urandom), 32, 1'($urandom));
    send_chan(1'b0, DW'($urandom), 4, 1'b0);
    end_test("random", 0, 1'b1);

    // Short channels: 24-bit words land in the top bits.
    apply_reset(1'b1, 24, 2);
    send_frame(32'h1234_5600, 24, 32'hABCD_EF00, 24, 1'b0);
    send_chan(1'b0, DW'($urandom), 4, 1'b0);
    end_test("short", 0, 1'b1);

    // Long channels: trailing ones beyond the word are ignored.
    apply_reset(1'b1, 40, 2);
    send_frame(DW'($urandom), 40, DW'($urandom), 40, 1'b1);
    send_chan(1'b0, DW'($urandom), 4, 1'b1);
    end_test("long", 0, 1'b1);

    // Backpressure over two frames: P2 overwrites P1 with one overflow pulse.
    apply_reset(1'b1, 32, 2);
    bus.out_ready = 1'b0;
    send_frame(DW'($urandom), 32, DW'($urandom), 32, 1'b0);
    p2_l = DW'($urandom);
    p2_r = DW'($urandom);
    send_frame(p2_l, 32, p2_r, 32, 1'b0);
    send_chan(1'b0, DW'($urandom), 4, 1'b0);
    check("bp_hold_left",  bus.left_chan,  p2_l);
    check("bp_hold_right", bus.right_chan, p2_r);
    check("bp_hold_valid", DW'(bus.out_valid), DW'(1));
    bus.out_ready = 1'b1;
    tick(1'b0, 1'b0);
    check("bp_valid_clear", DW'(bus.out_valid), '0);
    end_test("backpressure", 1, 1'b0);

    // Reset mid-left-channel: the partial frame yields no pair.
    apply_reset(1'b1, 32, 2);
    send_frame(DW'($urandom), 32, DW'($urandom), 32, 1'b0);
    send_chan(1'b0, DW'($urandom), 16, 1'b0);
    apply_reset(1'b0, 32, 2);
    send_chan(1'b0, DW'($urandom), 16, 1'b0);
    send_chan(1'b1, DW'($urandom), 32, 1'b0);
    check("partial_no_pair", DW'(valid_cnt), '0);
    wl = DW'($urandom);
    wr = DW'($urandom);
    send_frame(wl, 32, wr, 32, 1'b0);
    check("resync_no_early_valid", DW'(valid_cnt), '0);
    send_chan(1'b0, DW'($urandom), 4, 1'b0);
    end_test("midreset", 0, 1'b1);

    // Left channel two cycles short: data still delivered, LSBs zero.
    apply_reset(1'b1, 32, 2);
    send_frame(DW'($urandom), 30, DW'($urandom), 32, 1'b0);
    send_chan(1'b0, DW'($urandom), 4, 1'b0);
    end_test("frame_check", 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
